// File: rtl/wb_queue.sv
// wb_queue: write-back buffer in front of the register file's single write port.
//
// Two producers share one enqueue slot. The ALU always wins; the load unit is
// accepted only when the ALU is idle. Accepted requests are kept in an N-entry
// in-order FIFO and drained one per cycle, unless wbStall blocks the drain.
// Pending values are forwarded to decode so it never reads a stale register.
//
// Ports:
//   CLK, Reset                    clock, asynchronous active-high reset
//   aluValid/aluReg/aluValue      ALU write-back request   -> aluReady
//   memValid/memReg/memValue      load write-back request  -> memReady
//   wbStall                       register-file write port busy this cycle
//   RegWrite/writeReg/writeValue  register-file write port (combinational)
//   srcA/srcB                     decode read sources
//   hitA/hitB, fwdA/fwdB          forwarding hit flags and youngest pending values
//   count                         number of valid entries (0..N)
module wb_queue #(
    parameter int W = 16,
    parameter int D = 4,
    parameter int N = 4
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 aluValid,
    input  logic [D-1:0]         aluReg,
    input  logic [W-1:0]         aluValue,
    output logic                 aluReady,
    input  logic                 memValid,
    input  logic [D-1:0]         memReg,
    input  logic [W-1:0]         memValue,
    output logic                 memReady,
    input  logic                 wbStall,
    output logic                 RegWrite,
    output logic [D-1:0]         writeReg,
    output logic [W-1:0]         writeValue,
    input  logic [D-1:0]         srcA,
    input  logic [D-1:0]         srcB,
    output logic                 hitA,
    output logic                 hitB,
    output logic [W-1:0]         fwdA,
    output logic [W-1:0]         fwdB,
    output logic [$clog2(N):0]   count
);

    localparam int PW = $clog2(N);
    localparam int CW = PW + 1;

    logic [D-1:0]  reg_q [N];
    logic [D-1:0]  reg_d [N];
    logic [W-1:0]  val_q [N];
    logic [W-1:0]  val_d [N];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          space_s;
    logic          store_s;
    logic          deq_s;
    logic [D-1:0]  enq_reg_s;
    logic [W-1:0]  enq_val_s;

    // Handshake, drain strobe and next-state for the FIFO.
    // Ready looks only at the registered count so wbStall never reaches it.
    always_comb begin
        space_s   = (count_q < CW'(N));
        aluReady  = space_s;
        memReady  = space_s && !aluValid;
        enq_reg_s = aluValid ? aluReg   : memReg;
        enq_val_s = aluValid ? aluValue : memValue;
        // Writes to r0 complete the handshake but are dropped here.
        store_s   = ((aluValid && aluReady) || (memValid && memReady))
                    && (enq_reg_s != {D{1'b0}});
        deq_s     = (count_q != {CW{1'b0}}) && !wbStall;

        reg_d  = reg_q;
        val_d  = val_q;
        head_d = head_q;
        tail_d = tail_q;
        if (store_s) begin
            reg_d[tail_q] = enq_reg_s;
            val_d[tail_q] = enq_val_s;
            tail_d        = tail_q + PW'(1);
        end else begin
            tail_d = tail_q;
        end
        if (deq_s) begin
            head_d = head_q + PW'(1);
        end else begin
            head_d = head_q;
        end

        case ({store_s, deq_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Register-file write port driven from the head entry.
    always_comb begin
        RegWrite = deq_s;
        if (count_q != {CW{1'b0}}) begin
            writeReg   = reg_q[head_q];
            writeValue = val_q[head_q];
        end else begin
            writeReg   = {D{1'b0}};
            writeValue = {W{1'b0}};
        end
    end

    // Forwarding: walk valid entries oldest to youngest so the last match wins.
    always_comb begin
        logic [PW-1:0] idx;
        hitA = 1'b0;
        hitB = 1'b0;
        fwdA = {W{1'b0}};
        fwdB = {W{1'b0}};
        idx  = {PW{1'b0}};
        for (int i = 0; i < N; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if ((srcA != {D{1'b0}}) && (reg_q[idx] == srcA)) begin
                    hitA = 1'b1;
                    fwdA = val_q[idx];
                end else begin
                    hitA = hitA;
                end
                if ((srcB != {D{1'b0}}) && (reg_q[idx] == srcB)) begin
                    hitB = 1'b1;
                    fwdB = val_q[idx];
                end else begin
                    hitB = hitB;
                end
            end else begin
                idx = idx;
            end
        end
    end

    assign count = count_q;

    // FIFO state; reset discards every pending entry immediately.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            for (int i = 0; i < N; i++) begin
                reg_q[i] <= {D{1'b0}};
                val_q[i] <= {W{1'b0}};
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            reg_q   <= reg_d;
            val_q   <= val_d;
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed self-checking bench for wb_queue.
// Accepted writes are pushed to a scoreboard queue; each drained write is
// popped and compared. Ready, count and forwarding are predicted from the
// scoreboard contents every cycle.
module tb_wb_queue;

    localparam int W = 16;
    localparam int D = 4;
    localparam int N = 4;

    logic         CLK = 1'b0;
    logic         Reset;
    logic         aluValid, memValid, wbStall;
    logic [D-1:0] aluReg, memReg, srcA, srcB;
    logic [W-1:0] aluValue, memValue;
    logic         aluReady, memReady, RegWrite, hitA, hitB;
    logic [D-1:0] writeReg;
    logic [W-1:0] writeValue, fwdA, fwdB;
    logic [2:0]   count;

    typedef struct packed {
        logic [D-1:0] r;
        logic [W-1:0] v;
    } ent_t;

    ent_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    wb_queue #(.W(W), .D(D), .N(N)) dut (
        .CLK(CLK), .Reset(Reset),
        .aluValid(aluValid), .aluReg(aluReg), .aluValue(aluValue), .aluReady(aluReady),
        .memValid(memValid), .memReg(memReg), .memValue(memValue), .memReady(memReady),
        .wbStall(wbStall),
        .RegWrite(RegWrite), .writeReg(writeReg), .writeValue(writeValue),
        .srcA(srcA), .srcB(srcB), .hitA(hitA), .hitB(hitB), .fwdA(fwdA), .fwdB(fwdB),
        .count(count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Youngest scoreboard entry for a source register.
    task automatic model_fwd(input logic [D-1:0] src, output logic hit, output logic [W-1:0] val);
        hit = 1'b0;
        val = 16'h0000;
        if (src != 4'd0) begin
            foreach (sb[i]) begin
                if (sb[i].r == src) begin
                    hit = 1'b1;
                    val = sb[i].v;
                end
            end
        end
    endtask

    // One cycle: entered at a negedge with inputs already driven.
    task automatic step(output logic acc_alu, output logic acc_mem);
        logic         rdy, rw, h;
        logic [W-1:0] f;
        #1;
        rdy = (sb.size() < N);
        rw  = (sb.size() != 0) && !wbStall;
        chk("aluReady", 32'(aluReady), 32'(rdy));
        chk("memReady", 32'(memReady), 32'(rdy && !aluValid));
        chk("count", 32'(count), 32'(sb.size()));
        chk("RegWrite", 32'(RegWrite), 32'(rw));
        if (sb.size() != 0) begin
            chk("writeReg", 32'(writeReg), 32'(sb[0].r));
            chk("writeValue", 32'(writeValue), 32'(sb[0].v));
        end else begin
            chk("writeReg_idle", 32'(writeReg), 32'h0);
            chk("writeValue_idle", 32'(writeValue), 32'h0);
        end
        model_fwd(srcA, h, f);
        chk("hitA", 32'(hitA), 32'(h));
        chk("fwdA", 32'(fwdA), 32'(f));
        model_fwd(srcB, h, f);
        chk("hitB", 32'(hitB), 32'(h));
        chk("fwdB", 32'(fwdB), 32'(f));
        acc_alu = aluValid && rdy;
        acc_mem = memValid && rdy && !aluValid;
        @(posedge CLK);
        if (rw) void'(sb.pop_front());
        if (acc_alu && aluReg != 4'd0) sb.push_back('{aluReg, aluValue});
        else if (acc_mem && memReg != 4'd0) sb.push_back('{memReg, memValue});
        @(negedge CLK);
    endtask

    task automatic alu_req(input logic [D-1:0] r, input logic [W-1:0] v);
        logic a, m;
        aluValid = 1'b1; aluReg = r; aluValue = v;
        step(a, m);
        aluValid = 1'b0;
    endtask

    task automatic drain(input int budget);
        logic a, m;
        aluValid = 1'b0; memValid = 1'b0; wbStall = 1'b0;
        for (int k = 0; k < budget; k++) begin
            step(a, m);
        end
    endtask

    initial begin
        logic a, m;
        int   n;
        Reset = 1'b1; aluValid = 1'b0; memValid = 1'b0; wbStall = 1'b0;
        aluReg = 4'd0; memReg = 4'd0; aluValue = 16'h0; memValue = 16'h0;
        srcA = 4'd0; srcB = 4'd0;
        @(negedge CLK);
        chk("rst_RegWrite", 32'(RegWrite), 32'h0);
        chk("rst_writeReg", 32'(writeReg), 32'h0);
        chk("rst_writeValue", 32'(writeValue), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_hitA", 32'(hitA), 32'h0);
        chk("rst_fwdB", 32'(fwdB), 32'h0);
        Reset = 1'b0;
        @(negedge CLK);

        // 1: single ALU write, forwarded while draining.
        srcA = 4'd3;
        alu_req(4'd3, 16'h1234);
        chk("t1_hitA", 32'(hitA), 32'h1);
        chk("t1_fwdA", 32'(fwdA), 32'h1234);
        drain(2);

        // 2: stalled fill, youngest forward, in-order drain.
        wbStall = 1'b1; srcA = 4'd1; srcB = 4'd2;
        alu_req(4'd1, 16'h0011);
        alu_req(4'd2, 16'h0022);
        alu_req(4'd1, 16'h0033);
        alu_req(4'd4, 16'h0044);
        step(a, m);
        chk("t2_fwdA_young", 32'(fwdA), 32'h0033);
        chk("t2_count_full", 32'(count), 32'h4);
        drain(5);

        // 3: simultaneous requests, ALU first then load.
        aluValid = 1'b1; aluReg = 4'd5; aluValue = 16'hAAAA;
        memValid = 1'b1; memReg = 4'd6; memValue = 16'hBBBB;
        step(a, m);
        chk("t3_mem_blocked", 32'(m), 32'h0);
        aluValid = 1'b0;
        step(a, m);
        chk("t3_mem_taken", 32'(m), 32'h1);
        memValid = 1'b0;
        drain(3);

        // 4: write to r0 is swallowed.
        srcA = 4'd0;
        alu_req(4'd0, 16'hFFFF);
        drain(2);

        // 5: full and stalled, then refill while draining across the wrap.
        wbStall = 1'b1; srcA = 4'd2; srcB = 4'd7;
        alu_req(4'd2, 16'h0201);
        alu_req(4'd3, 16'h0302);
        alu_req(4'd2, 16'h0203);
        alu_req(4'd5, 16'h0504);
        for (int k = 0; k < 3; k++) begin
            aluValid = 1'b1; aluReg = 4'd6; aluValue = 16'h0600;
            step(a, m);
            chk("t5_no_accept", 32'(a), 32'h0);
        end
        wbStall = 1'b0;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            aluValid = 1'b1;
            aluReg   = 4'((n % 7) + 1);
            aluValue = 16'h0100 + 16'(n);
            step(a, m);
            if (a) n++;
        end
        aluValid = 1'b0;
        drain(6);

        // 6: asynchronous reset in the middle of a cycle with three pending.
        wbStall = 1'b1; srcA = 4'd2; srcB = 4'd3;
        alu_req(4'd1, 16'h0001);
        alu_req(4'd2, 16'h0002);
        alu_req(4'd3, 16'h0003);
        wbStall = 1'b0;
        #1;
        chk("t6_pre_RegWrite", 32'(RegWrite), 32'h1);
        chk("t6_pre_count", 32'(count), 32'h3);
        #1;
        Reset = 1'b1;
        #1;
        chk("t6_RegWrite", 32'(RegWrite), 32'h0);
        chk("t6_count", 32'(count), 32'h0);
        chk("t6_hitA", 32'(hitA), 32'h0);
        chk("t6_hitB", 32'(hitB), 32'h0);
        sb.delete();
        @(negedge CLK);
        Reset = 1'b0;
        srcA = 4'd7;
        alu_req(4'd7, 16'h0007);
        chk("t6_r7_first", 32'(writeReg), 32'h7);
        drain(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Write-back buffer that sits in front of the register file's single write port.
- Accepts write-back requests from two producers: the ALU (high priority) and the load/memory unit (low priority).
- Holds requests in an N-entry in-order FIFO and drains one entry per cycle onto RegWrite/writeReg/writeValue.
- While entries are pending, forwards the youngest pending value for either read source so that decode never reads a stale register.

Parameters:
W, 16, data width; matches the register file width.
D, 4, register address width (2**D registers; register 0 hard-wired to zero).
N, 4, FIFO depth; power of two, minimum 2.

Ports:
CLK  input  1  clock; all state updates on posedge.
Reset  input  1  asynchronous, active-high reset.
aluValid  input  1  ALU write-back request.
aluReg  input  D  ALU destination register.
aluValue  input  W  ALU result.
aluReady  output  1  ALU request accepted this cycle.
memValid  input  1  load-unit write-back request.
memReg  input  D  load destination register.
memValue  input  W  load data.
memReady  output  1  load request accepted this cycle.
wbStall  input  1  register-file write port unavailable this cycle; blocks the drain.
RegWrite  output  1  write strobe to the register file.
writeReg  output  D  register-file write address.
writeValue  output  W  register-file write data.
srcA  input  D  read source A from decode.
srcB  input  D  read source B from decode.
hitA  output  1  a pending entry targets srcA.
hitB  output  1  a pending entry targets srcB.
fwdA  output  W  youngest pending value for srcA.
fwdB  output  W  youngest pending value for srcB.
count  output  $clog2(N)+1  number of valid entries.

Behaviour:
- Reset (async, immediate):
  - head, tail and count go to 0.
  - RegWrite=0, writeReg=0, writeValue=0, hitA=hitB=0, fwdA=fwdB=0.
  - Reset mid-drain discards all pending entries; no write is issued.
- Handshake:
  - At most one enqueue per cycle.
  - aluReady = (count<N).
  - memReady = (count<N) && !aluValid; the ALU always wins.
  - A transfer occurs on a posedge where Valid && Ready.
  - A source holds Valid, Reg and Value stable until it sees Ready.
- Ready uses registered count only. A full queue that is draining in the same cycle still deasserts ready; this is intentional, to avoid a combinational path from wbStall to the ready outputs.
- Register 0:
  - An accepted request with Reg==0 completes the handshake but is not stored.
  - count is unchanged by it.
- Drain:
  - deq = (count!=0) && !wbStall.
  - RegWrite = deq, combinational.
  - writeReg and writeValue come from the head entry when count!=0, otherwise 0.
  - On a posedge with deq, head advances, wrapping modulo N.
- Latency: a request accepted at edge k drives RegWrite in the cycle after edge k at the earliest, so the register file is updated at edge k+1.
- Ordering:
  - Strict FIFO; entries drain in acceptance order.
  - Two entries to the same register both drain, so the older write is overwritten by the younger in the register file.
- Count update:
  - Simultaneous enqueue (stored) and dequeue leaves count unchanged; the tail advances and the head advances.
  - Enqueue alone: count+1.
  - Dequeue alone: count-1.
- Forwarding (combinational):
  - hitA=1 iff srcA!=0 and any valid entry, including the head being drained this cycle, has reg==srcA.
  - fwdA = value of the youngest such entry; the youngest is the one nearest tail-1 going backwards.
  - hitA=0 forces fwdA=0. B is identical.
  - Requests arriving in the current cycle are not visible to forwarding until after they are accepted.
- Overflow and underflow are impossible by construction: no enqueue when count==N, no dequeue when count==0.
- Pointer width is $clog2(N); count distinguishes full (N) from empty (0).

Test Plan:
1. Reset, then ALU writes r3=0x1234 with wbStall=0 -> aluReady=1; next cycle RegWrite=1, writeReg=3, writeValue=0x1234, hitA=1 (srcA=3), fwdA=0x1234; count returns to 0 the following cycle.
2. wbStall=1; ALU enqueues r1=0x11, r2=0x22, r1=0x33, r4=0x44 -> count=4, aluReady=0, srcA=1 gives fwdA=0x33; release wbStall -> four writes in order r1,r2,r1,r4 on consecutive cycles.
3. aluValid and memValid asserted together (r5=0xAAAA, r6=0xBBBB) -> ALU accepted first with memReady=0; mem accepted next cycle; writes drain r5 then r6.
4. ALU writes r0=0xFFFF -> aluReady=1, count stays 0, RegWrite never asserts, and srcA=0 gives hitA=0, fwdA=0.
5. With the queue full and wbStall=1 for 3 cycles -> no RegWrite and ready held low; then drop wbStall while enqueuing one entry each cycle the queue drops below N -> pointers wrap past N-1 with order preserved.
6. Assert Reset asynchronously mid-cycle with count=3 -> RegWrite, count, hitA and hitB go to 0 immediately; after release, a new r7=0x0007 write drains first.
